button_press_classifier: RTL and testbench

BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

---
 rtl/button_press_classifier.sv | 176 +++++++++++++++++
 tb/tb_button_press_classifier.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_classifier.sv
// Classifies debounced button activity into press/release edges and short, long and double presses.
// Optional auto-repeat while long-held is built when BUTTON_PRESS_CLASSIFIER_REPEAT_EN is defined.
module button_press_classifier #(
  parameter int unsigned Long_Press_Cycles          = 35_000_000,
  parameter int unsigned Double_Press_Window_Cycles = 10_500_000,
  parameter int unsigned Repeat_Cycles              = 7_000_000
) (
  input  logic clk,
  input  logic async_rst,
  input  logic clk_en,
  input  logic debounced_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_pulse,
  output logic busy
);

  localparam int unsigned MaxLw = (Long_Press_Cycles > Double_Press_Window_Cycles) ?
                                  Long_Press_Cycles : Double_Press_Window_Cycles;
  localparam int unsigned MaxCycles = (MaxLw > Repeat_Cycles) ? MaxLw : Repeat_Cycles;
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] LongLim = CntW'(Long_Press_Cycles - 1);
  localparam logic [CntW-1:0] WinLim  = CntW'(Double_Press_Window_Cycles - 1);

  if (Long_Press_Cycles < 2 || Double_Press_Window_Cycles < 2 || Repeat_Cycles < 2) begin : g_param_check
    $error("button_press_classifier: all cycle parameters must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            level_prev_q;
  logic            rise, fall;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            double_q, double_d;
  logic            busy_q, busy_d;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
  localparam logic [CntW-1:0] RepLim = CntW'(Repeat_Cycles - 1);
  logic repeat_q, repeat_d;
`endif

  always_comb begin
    rise      = debounced_level & ~level_prev_q;
    fall      = ~debounced_level & level_prev_q;
    // Saturating increment: the counter parks at all-ones instead of wrapping.
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = rise;
    release_d = fall;
    short_d   = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
    repeat_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (debounced_level && cnt_q == LongLim) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else if (fall) begin
          state_d = WAIT_SECOND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
        else if (cnt_q == RepLim) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      WAIT_SECOND: begin
        // A rise on the expiry cycle is still a double press.
        if (rise) begin
          state_d  = SECOND_PRESSED;
          double_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == WinLim) begin
          state_d = IDLE;
          short_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
      double_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
      repeat_q     <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_prev_q <= debounced_level;
      press_q      <= press_d;
      release_q    <= release_d;
      short_q      <= short_d;
      long_q       <= long_d;
      double_q     <= double_d;
      busy_q       <= busy_d;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
      repeat_q     <= repeat_d;
`endif
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign double_press  = double_q;
  assign busy          = busy_q;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
  assign repeat_pulse  = repeat_q;
`else
  assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier (Long=8, Window=5, Repeat=4) with a timestamp-based reference model.
module tb_button_press_classifier;

  localparam int LongCycles   = 8;
  localparam int WindowCycles = 5;
  localparam int RepeatCycles = 4;
`ifdef BUTTON_PRESS_CLASSIFIER_REPEAT_EN
  localparam bit RepeatEn = 1'b1;
`else
  localparam bit RepeatEn = 1'b0;
`endif
  localparam int ExpRepeatsS2 = RepeatEn ? 2 : 0;

  logic clk = 1'b0;
  logic async_rst, clk_en, debounced_level;
  logic press_pulse, release_pulse, short_press, long_press, double_press, repeat_pulse, busy;

  button_press_classifier #(
    .Long_Press_Cycles          (LongCycles),
    .Double_Press_Window_Cycles (WindowCycles),
    .Repeat_Cycles              (RepeatCycles)
  ) dut (
    .clk             (clk),
    .async_rst       (async_rst),
    .clk_en          (clk_en),
    .debounced_level (debounced_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .short_press     (short_press),
    .long_press      (long_press),
    .double_press    (double_press),
    .repeat_pulse    (repeat_pulse),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: episode described by timestamps of enabled edges; -1 means "not happened".
  int   n = 0;
  logic m_prev = 1'b0;
  int   t_press = -1, t_long = -1, t_rel = -1, t_second = -1;
  logic [6:0] exp_v = '0;  // {press, release, short, long, double, repeat, busy}

  logic [6:0] prev_obs = '0;
  int n_press, n_rel, n_short, n_long, n_dbl, n_rep;
  int at_press, at_rel, at_short, at_long;

  task automatic end_episode();
    t_press = -1; t_long = -1; t_rel = -1; t_second = -1;
  endtask

  task automatic model_clear();
    end_episode();
    m_prev = 1'b0;
    exp_v  = '0;
  endtask

  task automatic model_edge(input logic lvl);
    logic r, f;
    logic [6:0] e;
    e = '0;
    r = lvl & ~m_prev;
    f = ~lvl & m_prev;
    e[6] = r;
    e[5] = f;
    if (t_press < 0) begin
      if (r) t_press = n;
    end else if (t_long >= 0) begin
      if (f) end_episode();
      else if (RepeatEn && ((n - t_long) % RepeatCycles == 0)) e[1] = 1'b1;
    end else if (t_second >= 0) begin
      if (f) end_episode();
    end else if (t_rel >= 0) begin
      if (r) begin
        e[2] = 1'b1;
        t_second = n;
      end else if (n - t_rel == WindowCycles) begin
        e[4] = 1'b1;
        end_episode();
      end
    end else begin
      if (lvl && (n - t_press == LongCycles)) begin
        e[3] = 1'b1;
        t_long = n;
      end else if (f) begin
        t_rel = n;
      end
    end
    e[0] = (t_press >= 0);
    exp_v = e;
    m_prev = lvl;
    n++;
  endtask

  function automatic logic [6:0] observed();
    return {press_pulse, release_pulse, short_press, long_press, double_press, repeat_pulse, busy};
  endfunction

  task automatic check_vec(input string tag);
    logic [6:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_dbl = 0; n_rep = 0;
    at_press = -1; at_rel = -1; at_short = -1; at_long = -1;
  endtask

  task automatic track();
    logic [6:0] obs, up;
    obs = observed();
    up  = obs & ~prev_obs;
    if (up[6]) begin n_press++; at_press = cyc; end
    if (up[5]) begin n_rel++;   at_rel   = cyc; end
    if (up[4]) begin n_short++; at_short = cyc; end
    if (up[3]) begin n_long++;  at_long  = cyc; end
    if (up[2]) n_dbl++;
    if (up[1]) n_rep++;
    prev_obs = obs;
  endtask

  task automatic step(input logic lvl, input logic en);
    debounced_level = lvl;
    clk_en = en;
    @(posedge clk);
    if (en) model_edge(lvl);
    #1;
    cyc++;
    check_vec("step");
    track();
  endtask

  // Asserts reset away from the clock edge, checks outputs clear at once and stay clear.
  task automatic mid_reset(input string tag, input logic lvl_after);
    #2;
    async_rst = 1'b1;
    model_clear();
    #1;
    check_vec(tag);
    for (int i = 0; i < 3; i++) begin
      clk_en = (i != 1);
      @(posedge clk);
      #1;
      cyc++;
      check_vec(tag);
    end
    debounced_level = lvl_after;
    async_rst = 1'b0;
    prev_obs = observed();
  endtask

  initial begin
    async_rst = 1'b1;
    clk_en = 1'b0;
    debounced_level = 1'b0;
    model_clear();
    clear_counts();
    #1;
    check_vec("reset_state");
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_hold");
    async_rst = 1'b0;
    repeat (3) step(1'b0, 1'b1);

    // Short press
    clear_counts();
    repeat (3) step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1);
    check_int("s1_press", n_press, 1);
    check_int("s1_release", n_rel, 1);
    check_int("s1_short", n_short, 1);
    check_int("s1_short_delay", at_short - at_rel, WindowCycles);
    check_int("s1_long", n_long, 0);
    check_int("s1_double", n_dbl, 0);

    // Long press
    clear_counts();
    repeat (20) step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    check_int("s2_long", n_long, 1);
    check_int("s2_long_delay", at_long - at_press, LongCycles);
    check_int("s2_repeat", n_rep, ExpRepeatsS2);
    check_int("s2_short", n_short, 0);
    check_int("s2_double", n_dbl, 0);

    // Double press
    clear_counts();
    repeat (2) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    check_int("s3_double", n_dbl, 1);
    check_int("s3_short", n_short, 0);
    check_int("s3_press", n_press, 2);

    // Second rise on the exact expiry cycle
    clear_counts();
    repeat (2) step(1'b1, 1'b1);
    repeat (WindowCycles) step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    check_int("s4_double", n_dbl, 1);
    check_int("s4_short", n_short, 0);

    // One cycle later: two separate short presses
    clear_counts();
    repeat (2) step(1'b1, 1'b1);
    repeat (WindowCycles + 1) step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    check_int("s4b_double", n_dbl, 0);
    check_int("s4b_short", n_short, 2);

    // Reset mid-PRESSED with 1-of-3 enable, counter at 5
    for (int i = 0; i < 17; i++) step(1'b1, (i % 3) == 0);
    mid_reset("s5_reset", 1'b0);
    clear_counts();
    for (int i = 0; i < 12; i++) step(1'b0, (i % 3) == 0);
    check_int("s5_quiet_press", n_press, 0);
    check_int("s5_quiet_short", n_short, 0);
    for (int i = 0; i < 30; i++) step(1'b1, (i % 3) == 0);
    check_int("s5_long_clocks", at_long - at_press, 3 * LongCycles);
    for (int i = 0; i < 6; i++) step(1'b0, (i % 3) == 0);
    repeat (8) step(1'b0, 1'b1);

    // Button held through reset release
    repeat (3) step(1'b1, 1'b1);
    mid_reset("held_reset", 1'b1);
    clear_counts();
    step(1'b1, 1'b1);
    check_int("held_press", n_press, 1);
    check_int("held_busy", int'(busy), 1);
    repeat (2) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);

    // Randomized level runs with mixed enable patterns and occasional resets
    for (int seg = 0; seg < 200; seg++) begin
      int unsigned len, mode;
      logic lvl;
      lvl  = (seg % 2) == 0;
      len  = $urandom_range(1, 12);
      mode = $urandom_range(0, 2);
      for (int unsigned k = 0; k < len; k++)
        step(lvl, (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 24) == 0) mid_reset("rand_reset", lvl);
    end
    repeat (12) step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
